// File: rtl/csr_addr_router.sv
// csr_addr_router
//   Routes one master CSR access at a time to one of SLAVE_CNT regfile ports.
//   Slave k owns the address window [base[k], base[k+1]). The lowest matching
//   k wins, and an empty window never matches. An address at or above
//   base[SLAVE_CNT], or one that matches no window, is unmapped.
//
//   Transaction timeline (cycle 0 is the cycle in which the strobe is accepted):
//     cycle 0      : IDLE. The request is decoded and registered.
//     cycle 1      : ISSUE. A one-cycle s_rd_o[k] or s_wr_o[k] pulse is
//                    driven when the address hits a slave.
//     cycle 2..    : WAIT, used only for mapped reads whose data did not come
//                    back during ISSUE.
//     RESP (1 cyc) : single-cycle m_rdval_o and/or m_err_o pulse. The FSM
//                    then returns to IDLE.
//
//   Handshake: m_rd_i/m_wr_i are sampled only on a rising edge where
//   m_ready_o=1, and m_ready_o is high only in IDLE. If both strobes are high,
//   the access is a read and the write is dropped. s_rdval_i is looked at
//   only in ISSUE/WAIT, and only for the selected slave.
//
// Optional feature (macro CSR_ADDR_ROUTER_TIMEOUT_EN):
//   When this macro is defined, a read that has waited TIMEOUT WAIT cycles
//   ends with an error response. When it is undefined, WAIT is left only when
//   the slave returns data.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   base_addr_i              (SLAVE_CNT+1) packed ascending base addresses
//   m_addr_i/m_wdata_i/m_be_i master request fields
//   m_rd_i/m_wr_i            master strobes
//   m_ready_o                router idle, able to accept a request
//   m_rdata_o/m_rdval_o/m_err_o  master response
//   s_addr_o/s_wdata_o/s_be_o    broadcast to slaves (address is the offset)
//   s_rd_o/s_wr_o            one-hot per-slave strobes
//   s_rdata_i/s_rdval_i      per-slave read return
//   dbg_state_o              current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 RESP)
module csr_addr_router #(
  parameter int                SLAVE_CNT = 3,
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = {DATA_W{1'b1}}
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [(SLAVE_CNT+1)*ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0]               m_addr_i,
  input  logic [DATA_W-1:0]               m_wdata_i,
  input  logic [DATA_W/8-1:0]             m_be_i,
  input  logic                            m_rd_i,
  input  logic                            m_wr_i,
  output logic                            m_ready_o,
  output logic [DATA_W-1:0]               m_rdata_o,
  output logic                            m_rdval_o,
  output logic                            m_err_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [DATA_W/8-1:0]             s_be_o,
  output logic [SLAVE_CNT-1:0]            s_rd_o,
  output logic [SLAVE_CNT-1:0]            s_wr_o,
  input  logic [SLAVE_CNT*DATA_W-1:0]     s_rdata_i,
  input  logic [SLAVE_CNT-1:0]            s_rdval_i,
  output logic [1:0]                      dbg_state_o
);

  localparam int IDX_W = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;

  // The counter is 16 bits wide, so TIMEOUT must lie in 1..65535.
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("csr_addr_router: TIMEOUT out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state;
  logic             cur_rd;
  logic             cur_hit;
  logic [IDX_W-1:0] cur_idx;

  // Decode of the incoming address. It feeds only registers.
  logic                 dec_hit;
  logic [IDX_W-1:0]     dec_idx;
  logic [ADDR_W-1:0]    dec_off;
  logic [SLAVE_CNT-1:0] dec_onehot;

  // Return path for the slave that was latched at accept.
  logic              sel_rdval;
  logic [DATA_W-1:0] sel_rdata;

  // The loop runs downward so that the lowest matching k is written last and wins.
  always_comb begin
    dec_hit    = 1'b0;
    dec_idx    = '0;
    dec_off    = '0;
    dec_onehot = '0;
    for (int k = SLAVE_CNT - 1; k >= 0; k--) begin
      if ((m_addr_i >= base_addr_i[k*ADDR_W +: ADDR_W]) &&
          (m_addr_i <  base_addr_i[(k+1)*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(k);
        dec_off = m_addr_i - base_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
    dec_onehot[dec_idx] = 1'b1;
  end

  always_comb begin
    sel_rdval = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < SLAVE_CNT; k++) begin
      if (cur_idx == IDX_W'(k)) begin
        sel_rdval = s_rdval_i[k];
        sel_rdata = s_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CSR_ADDR_ROUTER_TIMEOUT_EN
  logic [15:0] wait_cnt;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      cur_rd    <= 1'b0;
      cur_hit   <= 1'b0;
      cur_idx   <= '0;
      m_ready_o <= 1'b1;
      m_rdata_o <= '0;
      m_rdval_o <= 1'b0;
      m_err_o   <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_be_o    <= '0;
      s_rd_o    <= '0;
      s_wr_o    <= '0;
`ifdef CSR_ADDR_ROUTER_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // Strobes and response flags are single-cycle pulses by default.
      s_rd_o    <= '0;
      s_wr_o    <= '0;
      m_rdval_o <= 1'b0;
      m_err_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_rd_i || m_wr_i) begin
            state     <= ST_ISSUE;
            m_ready_o <= 1'b0;
            cur_rd    <= m_rd_i;
            cur_hit   <= dec_hit;
            cur_idx   <= dec_idx;
            // Slave-side fields change only when a slave is actually
            // accessed, so they keep the last issued values otherwise.
            if (dec_hit) begin
              s_addr_o  <= dec_off;
              s_wdata_o <= m_wdata_i;
              s_be_o    <= m_be_i;
              if (m_rd_i) s_rd_o <= dec_onehot;
              else        s_wr_o <= dec_onehot;
            end
          end
        end
        ST_ISSUE: begin
`ifdef CSR_ADDR_ROUTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (!cur_rd) begin
            state   <= ST_RESP;
            m_err_o <= !cur_hit;
          end else if (!cur_hit) begin
            state     <= ST_RESP;
            m_rdval_o <= 1'b1;
            m_err_o   <= 1'b1;
            m_rdata_o <= ERR_RDATA;
          end else if (sel_rdval) begin
            state     <= ST_RESP;
            m_rdval_o <= 1'b1;
            m_rdata_o <= sel_rdata;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_rdval) begin
            state     <= ST_RESP;
            m_rdval_o <= 1'b1;
            m_rdata_o <= sel_rdata;
          end
`ifdef CSR_ADDR_ROUTER_TIMEOUT_EN
          // wait_cnt holds the number of WAIT cycles already spent, so the
          // TIMEOUT-th silent cycle is the one that gives up.
          else if (wait_cnt == 16'(TIMEOUT - 1)) begin
            state     <= ST_RESP;
            m_rdval_o <= 1'b1;
            m_err_o   <= 1'b1;
            m_rdata_o <= ERR_RDATA;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          m_ready_o <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          m_ready_o <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state_o = state;

endmodule

// File: tb/tb_csr_addr_router.sv
// Bench for csr_addr_router: SLAVE_CNT=3, bases {0,9,41,59}, DATA_W=16,
// TIMEOUT=16. Driver tasks issue requests and play the slaves. Any response
// with a pulse (m_rdval_o or m_err_o) is checked by a monitor against exp_q.
// Each queue entry holds {rdval, err, rdata, cycle}.
module tb_csr_addr_router;

  localparam int SC = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 16;

  logic               clk;
  logic               rst_n_i;
  logic [(SC+1)*AW-1:0] base_addr_i;
  logic [AW-1:0]      m_addr_i;
  logic [DW-1:0]      m_wdata_i;
  logic [DW/8-1:0]    m_be_i;
  logic               m_rd_i;
  logic               m_wr_i;
  logic               m_ready_o;
  logic [DW-1:0]      m_rdata_o;
  logic               m_rdval_o;
  logic               m_err_o;
  logic [AW-1:0]      s_addr_o;
  logic [DW-1:0]      s_wdata_o;
  logic [DW/8-1:0]    s_be_o;
  logic [SC-1:0]      s_rd_o;
  logic [SC-1:0]      s_wr_o;
  logic [SC*DW-1:0]   s_rdata_i;
  logic [SC-1:0]      s_rdval_i;
  logic [1:0]         dbg_state_o;

  csr_addr_router #(
    .SLAVE_CNT(SC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .base_addr_i(base_addr_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i),
    .m_rd_i(m_rd_i), .m_wr_i(m_wr_i), .m_ready_o(m_ready_o),
    .m_rdata_o(m_rdata_o), .m_rdval_o(m_rdval_o), .m_err_o(m_err_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o),
    .s_rd_o(s_rd_o), .s_wr_o(s_wr_o), .s_rdata_i(s_rdata_i),
    .s_rdval_i(s_rdval_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- scoreboard ----------------
  logic [49:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] c0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic rdval, input logic err, input logic [15:0] rdata,
                          input logic [31:0] due);
    exp_q.push_back({rdval, err, rdata, due});
  endtask

  always @(negedge clk) begin
    if (m_rdval_o || m_err_o) begin
      logic [49:0] e;
      logic [49:0] g;
      n_vec++;
      g = {m_rdval_o, m_err_o, m_rdata_o, cyc};
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL resp_unexpected: got rdval=%0b err=%0b rdata=0x%0h at cycle %0d, required none",
                 m_rdval_o, m_err_o, m_rdata_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (g !== e)begin
          n_miss++;
          $display("FAIL resp: got rdval=%0b err=%0b rdata=0x%0h cycle=%0d, required rdval=%0b err=%0b rdata=0x%0h cycle=%0d",
                   g[49], g[48], g[47:32], g[31:0], e[49], e[48], e[47:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left at a falling edge.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!m_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready_o) begin
      n_vec++;
      n_miss++;
      $display("FAIL ready_timeout: got m_ready_o=0 after 2000 cycles, required 1");
    end
  endtask

  // Drives the request during cycle 0 and returns at the falling edge of cycle 1.
  task automatic start_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
    wait_ready();
    m_addr_i  = addr;
    m_wdata_i = wd;
    m_be_i    = be;
    m_rd_i    = rd;
    m_wr_i    = wr;
    c0        = cyc;
    @(negedge clk);
    m_rd_i = 1'b0;
    m_wr_i = 1'b0;
  endtask

  // Called at cycle 1: slave k raises rdval L cycles after its s_rd_o pulse.
  task automatic slave_ret(input int k, input int lat, input logic [DW-1:0] data);
    repeat (lat) @(negedge clk);
    s_rdata_i[k*DW +: DW] = data;
    s_rdval_i[k] = 1'b1;
    @(negedge clk);
    s_rdval_i = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    base_addr_i = {10'd59, 10'd41, 10'd9, 10'd0};
    m_addr_i = '0; m_wdata_i = '0; m_be_i = '0; m_rd_i = 1'b0; m_wr_i = 1'b0;
    s_rdata_i = '0; s_rdval_i = '0;
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(m_ready_o), 32'd1);
    check("rst_strobes", {26'd0, s_rd_o, s_wr_o}, 32'd0);
    check("rst_resp", {30'd0, m_rdval_o, m_err_o}, 32'd0);
    check("rst_rdata", 32'(m_rdata_o), 32'd0);
    check("rst_saddr", 32'(s_addr_o), 32'd0);
    check("rst_swdata_be", {14'd0, s_wdata_o, s_be_o}, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk);

    // Write to 45: slave 2 (base 41), offset 4.
    start_req(1'b1 ^ 1'b1, 1'b1, 10'd45, 16'h1234, 2'b11);
    check("wr45_s_wr", 32'(s_wr_o), 32'b100);
    check("wr45_s_rd", 32'(s_rd_o), 32'd0);
    check("wr45_s_addr", 32'(s_addr_o), 32'd4);
    check("wr45_s_wdata", 32'(s_wdata_o), 32'h1234);
    check("wr45_s_be", 32'(s_be_o), 32'd3);
    @(negedge clk);
    check("wr45_c2_err_ready", {30'd0, m_err_o, m_ready_o}, 32'd0);
    @(negedge clk);
    check("wr45_c3_ready", 32'(m_ready_o), 32'd1);

    // Read 10: slave 1, offset 1, L=3. Slave 0 raises rdval as noise and must be ignored.
    start_req(1'b1, 1'b0, 10'd10, 16'h0000, 2'b11);
    check("rd10_s_rd", 32'(s_rd_o), 32'b010);
    check("rd10_s_addr", 32'(s_addr_o), 32'd1);
    push_exp(1'b1, 1'b0, 16'hBEEF, c0 + 32'd5);
    @(negedge clk);
    s_rdata_i[0 +: DW] = 16'h1111;
    s_rdval_i = 3'b001;
    @(negedge clk);
    s_rdval_i = '0;
    @(negedge clk);
    slave_ret(1, 0, 16'hBEEF);
    wait_ready();

    // Read 59 (== base[3]): unmapped.
    start_req(1'b1, 1'b0, 10'd59, 16'h0000, 2'b11);
    check("rd59_strobes", {26'd0, s_rd_o, s_wr_o}, 32'd0);
    push_exp(1'b1, 1'b1, 16'hFFFF, c0 + 32'd2);
    wait_ready();

    // Unmapped write: error only, rdata holds 0xFFFF, s_addr_o holds 1.
    start_req(1'b0, 1'b1, 10'd100, 16'h5555, 2'b01);
    check("wr100_strobes", {26'd0, s_rd_o, s_wr_o}, 32'd0);
    check("wr100_s_addr_hold", 32'(s_addr_o), 32'd1);
    push_exp(1'b0, 1'b1, 16'hFFFF, c0 + 32'd2);
    wait_ready();

    // Read 8: top address of slave 0, L=0.
    start_req(1'b1, 1'b0, 10'd8, 16'h0000, 2'b11);
    check("rd8_s_rd", 32'(s_rd_o), 32'b001);
    check("rd8_s_addr", 32'(s_addr_o), 32'd8);
    push_exp(1'b1, 1'b0, 16'h0A5A, c0 + 32'd2);
    slave_ret(0, 0, 16'h0A5A);
    wait_ready();

    // Read 41: first address of slave 2, L=1.
    start_req(1'b1, 1'b0, 10'd41, 16'h0000, 2'b11);
    check("rd41_s_rd", 32'(s_rd_o), 32'b100);
    check("rd41_s_addr", 32'(s_addr_o), 32'd0);
    push_exp(1'b1, 1'b0, 16'h4100, c0 + 32'd3);
    slave_ret(2, 1, 16'h4100);
    wait_ready();

    // Both strobes, addr 20: read slave 1 offset 11, no write.
    start_req(1'b1, 1'b1, 10'd20, 16'hDEAD, 2'b11);
    check("both_s_rd", 32'(s_rd_o), 32'b010);
    check("both_s_wr", 32'(s_wr_o), 32'd0);
    check("both_s_addr", 32'(s_addr_o), 32'd11);
    push_exp(1'b1, 1'b0, 16'h0020, c0 + 32'd2);
    slave_ret(1, 0, 16'h0020);
    wait_ready();

    // Read 0 with a silent slave.
    start_req(1'b1, 1'b0, 10'd0, 16'h0000, 2'b11);
    check("rd0_s_rd", 32'(s_rd_o), 32'b001);
`ifdef CSR_ADDR_ROUTER_TIMEOUT_EN
    push_exp(1'b1, 1'b1, 16'hFFFF, c0 + 32'd18);
    wait_ready();
    // A return that arrives after the timeout must be ignored.
    slave_ret(0, 0, 16'h7777);
    repeat (3) @(negedge clk);
`else
    begin
      logic stuck_ok;
      stuck_ok = 1'b1;
      repeat (1000) begin
        @(negedge clk);
        if (m_ready_o) stuck_ok = 1'b0;
      end
      check("rd0_no_timeout_ready_low", 32'(stuck_ok), 32'd1);
      rst_n_i = 1'b0;
      @(negedge clk);
      rst_n_i = 1'b1;
      @(negedge clk);
    end
`endif
    check("rd0_after_ready", 32'(m_ready_o), 32'd1);

    // Reset during WAIT, then a late return from the slave after reset is released.
    start_req(1'b1, 1'b0, 10'd30, 16'h0000, 2'b11);
    check("rd30_s_rd", 32'(s_rd_o), 32'b010);
    repeat (2) @(negedge clk);
    check("rd30_in_wait", 32'(dbg_state_o), 32'd2);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    slave_ret(1, 0, 16'h3333);
    repeat (3) @(negedge clk);
    check("rstmid_ready", 32'(m_ready_o), 32'd1);
    check("rstmid_strobes", {26'd0, s_rd_o, s_wr_o}, 32'd0);
    check("rstmid_rdval", 32'(m_rdval_o), 32'd0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/csr_addr_router.md
CSR_ADDR_ROUTER -- requirements
Module: csr_addr_router

Interface
REQ-001 SLAVE_CNT, default 3: number of slave regfile ports.
REQ-002 ADDR_W, default 10: address width, master and slave side.
REQ-003 DATA_W, default 16: data width; BE_W = DATA_W/8.
REQ-004 TIMEOUT, default 255: WAIT-cycle read timeout, range 1..65535.
REQ-005 ERR_RDATA, default all-ones (DATA_W bits): read data returned on any error.
REQ-006 clk_i  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n_i  in  1  asynchronous, active-low reset.
REQ-008 base_addr_i  in  (SLAVE_CNT+1)xADDR_W  ascending bases; slave k owns [base[k], base[k+1]).
REQ-009 m_addr_i / m_wdata_i / m_be_i  in  ADDR_W / DATA_W / BE_W  master request fields.
REQ-010 m_rd_i / m_wr_i  in  1 / 1  master read/write strobes, accepted only while m_ready_o=1.
REQ-011 m_ready_o  out  1  high only in IDLE.
REQ-012 m_rdata_o / m_rdval_o / m_err_o  out  DATA_W / 1 / 1  response data, read-valid pulse, error pulse.
REQ-013 s_addr_o / s_wdata_o / s_be_o  out  ADDR_W / DATA_W / BE_W  broadcast to all slaves; s_addr_o is the offset (addr - base[k]).
REQ-014 s_rd_o / s_wr_o  out  SLAVE_CNT / SLAVE_CNT  one-hot per-slave strobes.
REQ-015 s_rdata_i / s_rdval_i  in  SLAVE_CNTxDATA_W / SLAVE_CNT  per-slave read return.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE on accepted strobe, ISSUE->RESP for writes and unmapped reads, ISSUE->WAIT for mapped reads not returned in ISSUE, WAIT->RESP on return or timeout, RESP->IDLE always.
REQ-017 At accept (cycle 0) address, wdata, be, op, hit flag, slave index and offset are registered; decode is never combinational to slave outputs.
REQ-018 Decode: lowest k with base[k] <= addr < base[k+1] wins; addr >= base[SLAVE_CNT] or no match is unmapped; empty ranges never hit.
REQ-019 ISSUE (cycle 1): exactly one of s_rd_o[k]/s_wr_o[k] high for one cycle on a hit; no strobe on unmapped.
REQ-020 m_rd_i and m_wr_i together: read performed, write discarded, no error.
REQ-021 s_rdval_i[k] is sampled in ISSUE and WAIT for the selected k only; other bits and any rdval outside those states are ignored.
REQ-022 Read latency: slave returning L cycles after its s_rd_o pulse (L>=0) gives m_rdval_o at cycle L+2 with the captured s_rdata_i.
REQ-023 RESP: m_rdval_o=1 for reads only; m_err_o=1 for unmapped access (read or write) or timeout; both single-cycle, registered.
REQ-024 Unmapped read/timeout: m_rdata_o=ERR_RDATA; m_rdata_o otherwise holds last value.
REQ-025 Write completion: RESP at cycle 2, m_ready_o high at cycle 3.
REQ-026 s_addr_o/s_wdata_o/s_be_o hold the last issued values between transactions.

Reset
REQ-027 Reset: state IDLE, m_ready_o=1, all strobes, m_rdval_o, m_err_o, m_rdata_o, s_addr_o, s_wdata_o, s_be_o = 0, timeout counter 0.
REQ-028 Reset mid-transaction aborts it: no response is ever produced; a late s_rdval_i after release is ignored.

Configuration
REQ-029 Macro CSR_ADDR_ROUTER_TIMEOUT_EN defined: counter clears in ISSUE, increments per WAIT cycle; after TIMEOUT consecutive WAIT cycles without return, enter RESP with error; later returns ignored.
REQ-030 Macro undefined: no counter logic; WAIT exits only on s_rdval_i; TIMEOUT parameter unused.

Verification (SLAVE_CNT=3, base={0,9,41,59}, DATA_W=16, TIMEOUT=16)
REQ-031 Write addr 45, data 0x1234, be 2'b11 -> cycle 1 s_wr_o=3'b100, s_addr_o=4, s_wdata_o=0x1234; m_err_o stays 0; m_ready_o=1 at cycle 3.
REQ-032 Read addr 10, slave 1 returns 0xBEEF with L=3 -> s_rd_o=3'b010 at cycle 1, s_addr_o=1; m_rdval_o=1 and m_rdata_o=0xBEEF at cycle 5.
REQ-033 Read addr 59 -> no strobes; cycle 2 m_rdval_o=1, m_err_o=1, m_rdata_o=0xFFFF.
REQ-034 Read addr 0, slave silent -> macro on: m_rdval_o=m_err_o=1, m_rdata_o=0xFFFF at cycle 18; macro off: m_ready_o stays 0 for 1000 cycles.
REQ-035 m_rd_i=m_wr_i=1, addr 20 -> only s_rd_o[1] pulses, s_wr_o stays 0.
REQ-036 rst_n_i low during WAIT, then slave rdval after release -> no m_rdval_o, m_ready_o=1, all strobes 0.
